// File: rtl/ysyx_23060278_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the FSM encoding, the PC next-value selector, reset PC and the NOP word.
package ysyx_23060278_ifu_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2,
    ST_DROP = 2'd3
  } ifu_state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_REDIRECT = 2'd1,
    PC_INCR     = 2'd2
  } pc_sel_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam int unsigned PC_STEP          = 4;

endpackage

// File: rtl/ysyx_23060278_ifu_if.sv
// Fetch bus, decode handshake and redirect signals of the IFU.
// Handshake rule: a transfer happens on a clock edge where valid && ready are both high.
interface ysyx_23060278_ifu_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_data;
  logic            rsp_err;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_fault;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output req_valid, req_addr, rsp_ready, inst_valid, inst, inst_pc, inst_fault,
    input  req_ready, rsp_valid, rsp_data, rsp_err, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, inst_valid, inst, inst_pc, inst_fault,
    output req_ready, rsp_valid, rsp_data, rsp_err, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_23060278_pc_reg.sv
// Program counter register: holds, steps by 4 (wrapping), or loads a word-aligned redirect target.
module ysyx_23060278_pc_reg
  import ysyx_23060278_ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  pc_sel_e         sel,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      unique case (sel)
        PC_REDIRECT: pc <= {redirect_pc[XLEN-1:2], 2'b00};
        PC_INCR:     pc <= pc + XLEN'(PC_STEP);
        default:     pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_23060278_ifu.sv
// Instruction fetch unit: one outstanding fetch, registered instruction output to decode,
// redirects from execute flush whatever fetch is in flight.
module ysyx_23060278_ifu
  import ysyx_23060278_ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_23060278_ifu_if.master         bus,
  output ifu_state_e                  dbg_state
);

  ifu_state_e      state, state_next;
  pc_sel_e         pc_sel;
  logic            capture;
  logic [XLEN-1:0] pc;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            inst_fault_q;

  ysyx_23060278_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .sel         (pc_sel),
    .redirect_pc (bus.redirect_pc),
    .pc          (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_REQ;
    end else begin
      state <= state_next;
    end
  end

  // Redirect outranks every other event; a request or response that completes
  // in the redirect cycle must still be drained or discarded.
  always_comb begin
    state_next = state;
    pc_sel     = PC_HOLD;
    capture    = 1'b0;
    unique case (state)
      ST_REQ: begin
        if (bus.redirect_valid) begin
          pc_sel     = PC_REDIRECT;
          state_next = bus.req_ready ? ST_DROP : ST_REQ;
        end else if (bus.req_ready) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.redirect_valid) begin
          pc_sel     = PC_REDIRECT;
          state_next = bus.rsp_valid ? ST_REQ : ST_DROP;
        end else if (bus.rsp_valid) begin
          capture    = 1'b1;
          state_next = ST_OUT;
        end
      end
      ST_OUT: begin
        if (bus.redirect_valid) begin
          pc_sel     = PC_REDIRECT;
          state_next = ST_REQ;
        end else if (bus.inst_ready) begin
          pc_sel     = PC_INCR;
          state_next = ST_REQ;
        end
      end
      ST_DROP: begin
        if (bus.redirect_valid) begin
          pc_sel = PC_REDIRECT;
        end
        if (bus.rsp_valid) begin
          state_next = ST_REQ;
        end
      end
      default: state_next = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q       <= NOP_INST;
      inst_pc_q    <= RESET_PC;
      inst_fault_q <= 1'b0;
    end else if (capture) begin
      inst_q       <= bus.rsp_data;
      inst_pc_q    <= pc;
      inst_fault_q <= bus.rsp_err;
    end
  end

  assign bus.req_valid  = (state == ST_REQ);
  assign bus.req_addr   = pc;
  assign bus.rsp_ready  = (state == ST_WAIT) || (state == ST_DROP);
  assign bus.inst_valid = (state == ST_OUT);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_fault = inst_fault_q;
  assign dbg_state      = state;

endmodule
